// File: rtl/store_buffer_pkg.sv
// Shared sizing constants and FSM encoding for the store buffer.
package store_buffer_pkg;

    localparam int CACHE_LINE_WIDTH = 256;
    localparam int ADDR_WIDTH       = 16;
    localparam int SB_ENTRIES       = 4;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_REQ  = 2'd1,
        SB_REL  = 2'd2
    } sb_state_e;

endpackage

// File: rtl/store_buffer_match.sv
// Address comparator plus youngest-first priority select over a circular buffer.
// Used twice by store_buffer: once for push coalescing, once for refill lookup.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int  ADDR_W = ADDR_WIDTH,
    parameter int  N      = SB_ENTRIES,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic [N-1:0]      valid,
    input  logic [ADDR_W-1:0] addr [N],
    input  logic [IDX_W-1:0]  head,
    input  logic [ADDR_W-1:0] key,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0] slot;

    // Walk from oldest (head) to youngest so the last match seen wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a value held (no latch).
        hit  = 1'b0;
        idx  = head;
        slot = head;
        for (int k = 0; k < N; k++) begin
            slot = head + IDX_W'(k);
            if (valid[slot] && (addr[slot] == key)) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write-back buffer: queues evicted dirty lines and drains them to memory one at a
// time over the petition/serviceReady handshake; answers refill lookups meanwhile.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int cache_line_width = CACHE_LINE_WIDTH,
    parameter int addr_width       = ADDR_WIDTH,
    parameter int NUM_ENTRIES      = SB_ENTRIES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        evict_valid,
    input  logic [addr_width-1:0]       evict_addr,
    input  logic [cache_line_width-1:0] evict_data,
    output logic                        evict_ready,
    input  logic [addr_width-1:0]       lookup_addr,
    output logic                        lookup_hit,
    output logic [cache_line_width-1:0] lookup_data,
    input  logic                        drain_req,
    output logic                        drained,
    output logic                        petitionSbArb,
    output logic [addr_width-1:0]       addrSbArb,
    output logic [cache_line_width-1:0] dataSbMem,
    output logic                        weSbArb,
    input  logic                        serviceReadySbArb
);

    localparam int             IDX_W    = $clog2(NUM_ENTRIES);
    localparam int             CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

    // Entry storage and FIFO bookkeeping.
    logic [NUM_ENTRIES-1:0]      valid_q, valid_d;
    logic [addr_width-1:0]       addr_q [NUM_ENTRIES];
    logic [cache_line_width-1:0] data_q [NUM_ENTRIES];
    logic [IDX_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;

    // Drain FSM and its registered memory-side outputs.
    sb_state_e                   state_q, state_d;
    logic                        petition_q, petition_d;
    logic [addr_width-1:0]       out_addr_q, out_addr_d;
    logic [cache_line_width-1:0] out_data_q, out_data_d;

    logic                        co_hit, lk_hit;
    logic [IDX_W-1:0]            co_idx, lk_idx, wr_idx;
    logic [NUM_ENTRIES-1:0]      head_oh;
    logic                        push, push_new, pop;

    // Every entry always drains on its own, so drain_req carries no extra behaviour.
    logic unused_drain_req;
    assign unused_drain_req = drain_req;

    // The head is either in flight or about to be latched into the memory-side
    // registers, so it is never a coalesce target.
    assign head_oh = NUM_ENTRIES'(1) << head_q;

    sb_match #(.ADDR_W(addr_width), .N(NUM_ENTRIES)) u_coalesce (
        .valid (valid_q & ~head_oh),
        .addr  (addr_q),
        .head  (head_q),
        .key   (evict_addr),
        .hit   (co_hit),
        .idx   (co_idx)
    );

    sb_match #(.ADDR_W(addr_width), .N(NUM_ENTRIES)) u_lookup (
        .valid (valid_q),
        .addr  (addr_q),
        .head  (head_q),
        .key   (lookup_addr),
        .hit   (lk_hit),
        .idx   (lk_idx)
    );

    assign evict_ready   = (count_q < FULL_CNT) | co_hit;
    assign push          = evict_valid & evict_ready;
    assign push_new      = push & ~co_hit;
    assign pop           = (state_q == SB_REQ) & serviceReadySbArb;
    assign wr_idx        = co_hit ? co_idx : tail_q;

    assign lookup_hit    = lk_hit;
    assign lookup_data   = lk_hit ? data_q[lk_idx] : '0;
    assign drained       = (count_q == '0) & (state_q == SB_IDLE);
    assign petitionSbArb = petition_q;
    assign weSbArb       = petition_q;
    assign addrSbArb     = out_addr_q;
    assign dataSbMem     = out_data_q;

    // Pointer, count and valid-bit updates for push and pop in the same cycle.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
        end
        if (push_new) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + IDX_W'(1);
        end
        count_d = count_q + CNT_W'(push_new) - CNT_W'(pop);
    end

    // Drain FSM: latch the head on REQ entry, hold it until accepted, then one idle cycle.
    always_comb begin
        state_d    = state_q;
        petition_d = petition_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        case (state_q)
            SB_IDLE, SB_REL: begin
                petition_d = 1'b0;
                state_d    = SB_IDLE;
                if (count_q != '0) begin
                    state_d    = SB_REQ;
                    petition_d = 1'b1;
                    out_addr_d = addr_q[head_q];
                    out_data_d = data_q[head_q];
                end
            end
            SB_REQ: begin
                if (serviceReadySbArb) begin
                    state_d    = SB_REL;
                    petition_d = 1'b0;
                end
            end
            default: begin
                state_d    = SB_IDLE;
                petition_d = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= SB_IDLE;
            petition_q <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            petition_q <= petition_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    // Line payload write port (new entry at tail or coalesce into an older entry).
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; valid bits alone decide whether an entry is visible.
        if (push) begin
            addr_q[wr_idx] <= evict_addr;
            data_q[wr_idx] <= evict_data;
        end
    end

endmodule
